// File: rtl/fpall_pkg.sv
// rtl/fpall_pkg.sv - fpall shared types, divider constants and rounding helpers.
// FP_ITER_DIV_FLAGS_EN adds the per-lane exception flag helper.
package fpall_pkg;

  typedef enum logic {FP32 = 1'b0, FP16 = 1'b1} fp_fmt_e;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] frac;
  } bf16_t;

  typedef struct packed {
    bf16_t hi;
    bf16_t lo;
  } bf16x2_t;

  typedef union packed {
    logic [31:0] raw;
    fp32_t       f32;
    bf16x2_t     b16;
  } fp_vec_u;

  typedef enum logic [2:0] {IDLE, PREP, ITER, ROUND, DONE} fp_div_state_e;

  typedef enum logic [2:0] {
    SPC_NONE, SPC_NAN, SPC_INVALID, SPC_DIVZ, SPC_INF, SPC_ZERO
  } fp_div_spc_e;

  localparam int DIV_Q_FP32 = 25;
  localparam int DIV_Q_BF16 = 9;

  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP32_INF  = 32'h7F80_0000;
  localparam logic [15:0] BF16_QNAN = 16'h7FC0;
  localparam logic [15:0] BF16_INF  = 16'h7F80;

  // exp==0 operands are flushed to zero before classification.
  function automatic fp_div_spc_e fp_div_classify(input logic [7:0] ex, input logic fx_nz,
                                                  input logic [7:0] ey, input logic fy_nz);
    logic zx, zy, ix, iy, nx, ny;
    zx = (ex == 8'h00);
    zy = (ey == 8'h00);
    ix = (&ex) && !fx_nz;
    iy = (&ey) && !fy_nz;
    nx = (&ex) && fx_nz;
    ny = (&ey) && fy_nz;
    if (nx || ny)                     return SPC_NAN;
    else if ((zx && zy) || (ix && iy)) return SPC_INVALID;
    else if (ix)                       return SPC_INF;
    else if (zy)                       return SPC_DIVZ;
    else if (zx || iy)                 return SPC_ZERO;
    else                               return SPC_NONE;
  endfunction

  // Returns {carry_out, rounded mantissa}; BF16 mantissas sit in bits [7:0].
  function automatic logic [25:0] fp_div_mant_rnd(input logic bf16, input logic [23:0] mant,
                                                  input logic g, input logic st);
    logic        inc;
    logic [24:0] m1;
    inc = g & (mant[0] | st);
    m1  = {1'b0, mant} + {24'd0, inc};
    return {(bf16 ? m1[8] : m1[24]), m1};
  endfunction

  function automatic logic [31:0] fp_div_round(input logic bf16, input logic sign,
                                               input logic signed [9:0] exp, input logic [23:0] mant,
                                               input logic g, input logic st, input fp_div_spc_e spc);
    logic [25:0]       rnd;
    logic signed [9:0] e;
    logic [31:0]       inf_v, nan_v, zero_v, fin_v;
    rnd    = fp_div_mant_rnd(bf16, mant, g, st);
    e      = exp + $signed({9'd0, rnd[25]});
    inf_v  = bf16 ? {16'h0, sign, BF16_INF[14:0]} : {sign, FP32_INF[30:0]};
    nan_v  = bf16 ? {16'h0, BF16_QNAN} : FP32_QNAN;
    zero_v = bf16 ? {16'h0, sign, 15'h0} : {sign, 31'h0};
    fin_v  = bf16 ? {16'h0, sign, e[7:0], rnd[6:0]} : {sign, e[7:0], rnd[22:0]};
    case (spc)
      SPC_NAN, SPC_INVALID: return nan_v;
      SPC_DIVZ, SPC_INF:    return inf_v;
      SPC_ZERO:             return zero_v;
      default: begin
        if (e >= 10'sd255)    return inf_v;
        else if (e <= 10'sd0) return zero_v;
        else                  return fin_v;
      end
    endcase
  endfunction

`ifdef FP_ITER_DIV_FLAGS_EN
  // {invalid, div_by_zero, overflow, underflow, inexact}
  function automatic logic [4:0] fp_div_flags(input logic bf16, input logic signed [9:0] exp,
                                              input logic [23:0] mant, input logic g,
                                              input logic st, input fp_div_spc_e spc);
    logic [25:0]       rnd;
    logic signed [9:0] e;
    logic              fin, ovf, unf, inx;
    rnd = fp_div_mant_rnd(bf16, mant, g, st);
    e   = exp + $signed({9'd0, rnd[25]});
    fin = (spc == SPC_NONE);
    ovf = fin && (e >= 10'sd255);
    unf = fin && (e <= 10'sd0);
    inx = fin && (g || st || ovf || unf);
    return {(spc == SPC_INVALID), (spc == SPC_DIVZ), ovf, unf, inx};
  endfunction
`endif

endpackage

// File: rtl/fp_iter_div_if.sv
// rtl/fp_iter_div_if.sv - operand/result handshake bundle for fp_iter_div.
// FP_ITER_DIV_FLAGS_EN adds the flags signal.
interface fp_iter_div_if;
  import fpall_pkg::*;

  logic        in_valid;
  logic        in_ready;
  fp_fmt_e     fmt;
  logic [31:0] X;
  logic [31:0] Y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] R;
`ifdef FP_ITER_DIV_FLAGS_EN
  logic [9:0]  flags;

  modport master (output in_valid, fmt, X, Y, out_ready,
                  input  in_ready, out_valid, R, flags);
  modport slave  (input  in_valid, fmt, X, Y, out_ready,
                  output in_ready, out_valid, R, flags);
`else
  modport master (output in_valid, fmt, X, Y, out_ready,
                  input  in_ready, out_valid, R);
  modport slave  (input  in_valid, fmt, X, Y, out_ready,
                  output in_ready, out_valid, R);
`endif

endinterface

// File: rtl/fp_div_step.sv
// rtl/fp_div_step.sv - one restoring radix-2 division step.
module fp_div_step #(
  parameter int W = 25
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] div,
  output logic         qbit,
  output logic [W-1:0] rem_next
);

  logic [W:0]   trial;
  logic [W-1:0] kept;

  // rem < 2*div on entry, so the kept remainder never uses its top bit.
  always_comb begin
    trial    = {1'b0, rem} - {1'b0, div};
    qbit     = ~trial[W];
    kept     = qbit ? trial[W-1:0] : rem;
    rem_next = {kept[W-2:0], 1'b0};
  end

endmodule

// File: rtl/fp_iter_div.sv
// rtl/fp_iter_div.sv - iterative FP32 / dual-BF16 restoring divider (fpall DIV).
// FP_ITER_DIV_FLAGS_EN adds the 10-bit per-lane exception flags output.
module fp_iter_div
  import fpall_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input logic         clk,
  input logic         rst_n,
  fp_iter_div_if.slave bus
);

  localparam int N32   = (DIV_Q_FP32 + UNROLL - 1) / UNROLL;
  localparam int N16   = (DIV_Q_BF16 + UNROLL - 1) / UNROLL;
  localparam int EXTRA = UNROLL - 1;
  localparam int QHW   = DIV_Q_FP32 + EXTRA;
  localparam int QLW   = DIV_Q_BF16 + EXTRA;

  generate
    if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
      $error("fp_iter_div: UNROLL must be 1 or 2");
    end
  endgenerate

  fp_div_state_e     state;
  fp_fmt_e           fmt_q;
  logic [31:0]       x_q, y_q;
  logic              in_ready_q, out_valid_q;
  logic [31:0]       r_q;
  logic              sign_hi, sign_lo;
  logic signed [9:0] exp_hi, exp_lo;
  logic [24:0]       rem_hi, div_hi;
  logic [8:0]        rem_lo, div_lo;
  logic [QHW-1:0]    q_hi;
  logic [QLW-1:0]    q_lo;
  fp_div_spc_e       spc_hi, spc_lo;
  logic [4:0]        cnt;

  fp_vec_u xv, yv;
  logic    is_bf16;

  assign xv.raw  = x_q;
  assign yv.raw  = y_q;
  assign is_bf16 = (fmt_q == FP16);

  // Unpack and pre-normalize; the hi datapath carries FP32 or the upper BF16 lane.
  logic [23:0]       mx_hi, my_hi;
  logic [7:0]        mx_lo, my_lo;
  logic              fnx_hi, fny_hi, lt_hi, lt_lo;
  logic [24:0]       p_rem_hi;
  logic [8:0]        p_rem_lo;
  logic signed [9:0] p_exp_hi, p_exp_lo;

  always_comb begin
    if (is_bf16) begin
      mx_hi  = {16'h0, 1'b1, xv.b16.hi.frac};
      my_hi  = {16'h0, 1'b1, yv.b16.hi.frac};
      fnx_hi = |xv.b16.hi.frac;
      fny_hi = |yv.b16.hi.frac;
    end else begin
      mx_hi  = {1'b1, xv.f32.frac};
      my_hi  = {1'b1, yv.f32.frac};
      fnx_hi = |xv.f32.frac;
      fny_hi = |yv.f32.frac;
    end
    mx_lo    = {1'b1, xv.b16.lo.frac};
    my_lo    = {1'b1, yv.b16.lo.frac};
    lt_hi    = (mx_hi < my_hi);
    lt_lo    = (mx_lo < my_lo);
    p_rem_hi = lt_hi ? {mx_hi, 1'b0} : {1'b0, mx_hi};
    p_rem_lo = lt_lo ? {mx_lo, 1'b0} : {1'b0, mx_lo};
    p_exp_hi = $signed({2'b00, xv.f32.exp}) - $signed({2'b00, yv.f32.exp})
             + (lt_hi ? 10'sd126 : 10'sd127);
    p_exp_lo = $signed({2'b00, xv.b16.lo.exp}) - $signed({2'b00, yv.b16.lo.exp})
             + (lt_lo ? 10'sd126 : 10'sd127);
  end

  logic [UNROLL:0][24:0] hi_chain;
  logic [UNROLL:0][8:0]  lo_chain;
  logic [UNROLL-1:0]     hi_qb, lo_qb;

  assign hi_chain[0] = rem_hi;
  assign lo_chain[0] = rem_lo;

  // First step of a cycle produces the most significant quotient bit.
  generate
    for (genvar i = 0; i < UNROLL; i++) begin : g_step
      fp_div_step #(.W(25)) u_hi (
        .rem      (hi_chain[i]),
        .div      (div_hi),
        .qbit     (hi_qb[UNROLL-1-i]),
        .rem_next (hi_chain[i+1])
      );
      fp_div_step #(.W(9)) u_lo (
        .rem      (lo_chain[i]),
        .div      (div_lo),
        .qbit     (lo_qb[UNROLL-1-i]),
        .rem_next (lo_chain[i+1])
      );
    end
  endgenerate

  // Any quotient bit beyond the guard (odd Q with UNROLL=2) folds into sticky.
  logic [24:0] qq_hi;
  logic [8:0]  qq_lo;
  logic        st_hi, st_lo;
  logic [23:0] mant_hi;
  logic [31:0] r_hi, r_next;
  logic [15:0] r_lo;

  always_comb begin
    qq_hi   = 25'(q_hi >> EXTRA);
    qq_lo   = 9'(q_lo >> EXTRA);
    st_hi   = (rem_hi != 25'd0) || ((EXTRA != 0) && q_hi[0]);
    st_lo   = (rem_lo != 9'd0) || ((EXTRA != 0) && q_lo[0]);
    mant_hi = is_bf16 ? {16'h0, qq_hi[8:1]} : qq_hi[24:1];
    r_hi    = fp_div_round(is_bf16, sign_hi, exp_hi, mant_hi, qq_hi[0], st_hi, spc_hi);
    r_lo    = 16'(fp_div_round(1'b1, sign_lo, exp_lo, {16'h0, qq_lo[8:1]}, qq_lo[0], st_lo, spc_lo));
    r_next  = is_bf16 ? {r_hi[15:0], r_lo} : r_hi;
  end

`ifdef FP_ITER_DIV_FLAGS_EN
  logic [9:0] flags_q, flags_next;
  logic [4:0] fl_hi, fl_lo;

  always_comb begin
    fl_hi      = fp_div_flags(is_bf16, exp_hi, mant_hi, qq_hi[0], st_hi, spc_hi);
    fl_lo      = fp_div_flags(1'b1, exp_lo, {16'h0, qq_lo[8:1]}, qq_lo[0], st_lo, spc_lo);
    flags_next = is_bf16 ? {fl_hi, fl_lo} : {5'b0, fl_hi};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               flags_q <= '0;
    else if (state == ROUND)  flags_q <= flags_next;
  end

  assign bus.flags = flags_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fmt_q       <= FP32;
      x_q         <= '0;
      y_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      r_q         <= '0;
      sign_hi     <= 1'b0;
      sign_lo     <= 1'b0;
      exp_hi      <= '0;
      exp_lo      <= '0;
      rem_hi      <= '0;
      rem_lo      <= '0;
      div_hi      <= '0;
      div_lo      <= '0;
      q_hi        <= '0;
      q_lo        <= '0;
      spc_hi      <= SPC_NONE;
      spc_lo      <= SPC_NONE;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            x_q        <= bus.X;
            y_q        <= bus.Y;
            fmt_q      <= bus.fmt;
            in_ready_q <= 1'b0;
            state      <= PREP;
          end
        end
        PREP: begin
          sign_hi <= xv.f32.sign ^ yv.f32.sign;
          sign_lo <= xv.b16.lo.sign ^ yv.b16.lo.sign;
          exp_hi  <= p_exp_hi;
          exp_lo  <= p_exp_lo;
          rem_hi  <= p_rem_hi;
          rem_lo  <= p_rem_lo;
          div_hi  <= {1'b0, my_hi};
          div_lo  <= {1'b0, my_lo};
          spc_hi  <= fp_div_classify(xv.f32.exp, fnx_hi, yv.f32.exp, fny_hi);
          spc_lo  <= fp_div_classify(xv.b16.lo.exp, |xv.b16.lo.frac,
                                     yv.b16.lo.exp, |yv.b16.lo.frac);
          q_hi    <= '0;
          q_lo    <= '0;
          cnt     <= is_bf16 ? 5'(N16 - 1) : 5'(N32 - 1);
          state   <= ITER;
        end
        ITER: begin
          rem_hi <= hi_chain[UNROLL];
          rem_lo <= lo_chain[UNROLL];
          q_hi   <= {q_hi[QHW-UNROLL-1:0], hi_qb};
          q_lo   <= {q_lo[QLW-UNROLL-1:0], lo_qb};
          if (cnt == 5'd0) state <= ROUND;
          else             cnt   <= cnt - 5'd1;
        end
        ROUND: begin
          r_q         <= r_next;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.R         = r_q;

endmodule

// File: tb/tb_fp_iter_div.sv
// tb/tb_fp_iter_div.sv - directed self-checking bench for fp_iter_div (UNROLL=1).
module tb_fp_iter_div;
  import fpall_pkg::*;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   passed = 0;

  fp_iter_div_if bus ();

  fp_iter_div #(.UNROLL(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    checks++;
    assert (obs === req) passed++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, req);
  endtask

  // Called #1 after the accepting edge; consumes the result with out_ready high.
  task automatic wait_result(input string tag, input logic [31:0] req_r, input int req_lat);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_R"}, 64'(bus.R), 64'(req_r));
    if (req_lat > 0) chk({tag, "_lat"}, 64'(lat), 64'(req_lat));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input fp_fmt_e f, input logic [31:0] x, input logic [31:0] y);
    int n;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    bus.fmt      = f;
    bus.X        = x;
    bus.Y        = y;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.X        = 32'hDEAD_BEEF;
    bus.Y        = 32'h0000_0001;
  endtask

  task automatic run_op(input string tag, input fp_fmt_e f, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] req_r, input int req_lat);
    bus.out_ready = 1'b1;
    start_op(f, x, y);
    wait_result(tag, req_r, req_lat);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.fmt       = FP32;
    bus.X         = '0;
    bus.Y         = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_R", 64'(bus.R), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("fp32_6div2",  FP32, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 27);
    run_op("fp32_1div3",  FP32, 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 27);
    run_op("fp32_neg",    FP32, 32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 0);
    run_op("bf16_pair",   FP16, 32'h4040_3F80, 32'h3F80_4040, 32'h4040_3EAB, 11);
    run_op("fp32_xdiv0",  FP32, 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 27);
    run_op("fp32_0div0",  FP32, 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 27);
    run_op("fp32_ovf",    FP32, 32'h7F00_0000, 32'h3F00_0000, 32'h7F80_0000, 0);
    run_op("fp32_unf",    FP32, 32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 0);
    run_op("fp32_infdiv", FP32, 32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 0);
    run_op("bf16_nanlane",FP16, 32'h7FC1_4000, 32'h3F80_3F80, 32'h7FC0_4000, 11);

    // Backpressure: result held while out_ready is low; held in_valid waits.
    bus.fmt       = FP16;
    bus.X         = 32'h4040_3F80;
    bus.Y         = 32'h3F80_4040;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.fmt = FP32;
    bus.X   = 32'h3F80_0000;
    bus.Y   = 32'h4040_0000;
    begin
      int lat;
      lat = 0;
      while (!bus.out_valid && lat < 100) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk("bp_lat", 64'(lat), 64'd11);
    end
    repeat (5) begin
      chk("bp_hold", 64'({bus.out_valid, bus.in_ready, bus.R}), 64'({1'b1, 1'b0, 32'h4040_3EAB}));
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release", 64'({bus.out_valid, bus.in_ready}), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_result("bp_next", 32'h3EAA_AAAB, 27);

    // Reset in the middle of ITER aborts the divide.
    start_op(FP32, 32'h3F80_0000, 32'h4040_0000);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out", 64'({bus.out_valid, bus.in_ready, bus.R}), 64'({1'b0, 1'b1, 32'h0}));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op("post_rst", FP32, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 27);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
